// File: rtl/sweep_sequencer.sv
// sweep_sequencer
// Receives a three-word sweep configuration over the UART word interface:
// start period, stop period, and dwell in ms. It then drives the square-wave
// generator through every period from start to stop. Each value is held for
// the dwell time. A sweep is stepped by STEP, and the last step is clamped
// so that it lands exactly on the stop period.
//
// Ports
//   clk_12mhz_int    in   1   system clock (12 MHz)
//   M_RESET_B        in   1   asynchronous active-low reset
//   uart_data_bus    in  16   received word, valid while uart_data_valid is high
//   uart_data_valid  in   1   level, high for >= 1 cycle per received frame
//   wave_period      out 16   division factor T to the generator
//   wave_enable      out  1   generator/PLL enable
//   step_strobe      out  1   1-cycle pulse when a new wave_period is applied in RUN
//   sweep_active     out  1   high while sweeping
//   sweep_done       out  1   high once a non-looping sweep has finished
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for the start-period word
// S_GET_STOP  | start captured, waiting for stop word (times out to IDLE)
// S_GET_DWELL | stop captured, waiting for dwell word (times out to IDLE)
// S_RUN       | generator enabled, stepping period once per dwell
// S_DONE      | sweep finished, generator off, a new word restarts config

module sweep_sequencer #(
    parameter int unsigned CLKS_PER_MS    = 12000,
    parameter logic [15:0] STEP           = 16'd1,
    parameter bit          LOOP           = 1'b0,
    parameter int unsigned CFG_TIMEOUT_MS = 1000
) (
    input  logic        clk_12mhz_int,
    input  logic        M_RESET_B,
    input  logic [15:0] uart_data_bus,
    input  logic        uart_data_valid,
    output logic [15:0] wave_period,
    output logic        wave_enable,
    output logic        step_strobe,
    output logic        sweep_active,
    output logic        sweep_done
);

    localparam int PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(CLKS_PER_MS - 1);
    localparam logic [15:0]      CFG_TO_M1  = 16'(CFG_TIMEOUT_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_STOP,
        S_GET_DWELL,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic             valid_q;
    logic             armed;
    logic [15:0]      start_t;
    logic [15:0]      stop_t;
    logic [15:0]      dwell;
    logic [PRE_W-1:0] pre_cnt;
    logic [15:0]      ms_left;

    logic             rise;
    logic             ms_tick;
    logic             dir_up;
    logic [15:0]      dwell_in;
    logic [16:0]      gap;
    logic [15:0]      next_period;

    // armed stays low after reset until the valid line has been seen low.
    // Without it, a level that is already high at reset release would be
    // taken as a fresh frame.
    always_comb begin
        rise     = uart_data_valid & ~valid_q & armed;
        ms_tick  = (pre_cnt == '0);
        dir_up   = (stop_t > start_t);
        dwell_in = (uart_data_bus == 16'd0) ? 16'd1 : uart_data_bus;
    end

    // Distance to stop is measured in 17 bits. When it is smaller than STEP,
    // the next value is clamped to stop. Otherwise the +/-STEP result cannot
    // wrap, because stop lies between the current value and 0/0xFFFF.
    always_comb begin
        gap         = 17'd0;
        next_period = stop_t;
        if (dir_up) begin
            gap = {1'b0, stop_t} - {1'b0, wave_period};
        end else begin
            gap = {1'b0, wave_period} - {1'b0, stop_t};
        end
        if (gap < {1'b0, STEP}) begin
            next_period = stop_t;
        end else if (dir_up) begin
            next_period = wave_period + STEP;
        end else begin
            next_period = wave_period - STEP;
        end
    end

    always_ff @(posedge clk_12mhz_int or negedge M_RESET_B) begin
        if (!M_RESET_B) begin
            state        <= S_IDLE;
            valid_q      <= 1'b0;
            armed        <= 1'b0;
            start_t      <= 16'd0;
            stop_t       <= 16'd0;
            dwell        <= 16'd0;
            pre_cnt      <= '0;
            ms_left      <= 16'd0;
            wave_period  <= 16'd0;
            wave_enable  <= 1'b0;
            step_strobe  <= 1'b0;
            sweep_active <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            valid_q     <= uart_data_valid;
            armed       <= armed | ~uart_data_valid;
            step_strobe <= 1'b0;

            // Free-running ms prescaler. State entries below reload it
            // together with the ms down-counter.
            if (ms_tick) begin
                pre_cnt <= PRE_RELOAD;
            end else begin
                pre_cnt <= pre_cnt - PRE_W'(1);
            end
            if (ms_tick && (ms_left != 16'd0)) begin
                ms_left <= ms_left - 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (rise) begin
                        start_t <= uart_data_bus;
                        pre_cnt <= PRE_RELOAD;
                        ms_left <= CFG_TO_M1;
                        state   <= S_GET_STOP;
                    end
                end

                S_GET_STOP: begin
                    if (rise) begin
                        stop_t  <= uart_data_bus;
                        pre_cnt <= PRE_RELOAD;
                        ms_left <= CFG_TO_M1;
                        state   <= S_GET_DWELL;
                    end else if (ms_tick && (ms_left == 16'd0)) begin
                        state <= S_IDLE;
                    end
                end

                S_GET_DWELL: begin
                    if (rise) begin
                        dwell        <= dwell_in;
                        pre_cnt      <= PRE_RELOAD;
                        ms_left      <= dwell_in - 16'd1;
                        wave_period  <= start_t;
                        wave_enable  <= 1'b1;
                        step_strobe  <= 1'b1;
                        sweep_active <= 1'b1;
                        state        <= S_RUN;
                    end else if (ms_tick && (ms_left == 16'd0)) begin
                        state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    // An abort takes priority over a dwell expiry in the same cycle.
                    if (rise) begin
                        wave_enable  <= 1'b0;
                        sweep_active <= 1'b0;
                        state        <= S_IDLE;
                    end else if (ms_tick && (ms_left == 16'd0)) begin
                        if (wave_period != stop_t) begin
                            wave_period <= next_period;
                            step_strobe <= 1'b1;
                            pre_cnt     <= PRE_RELOAD;
                            ms_left     <= dwell - 16'd1;
                        end else if (LOOP) begin
                            wave_period <= start_t;
                            step_strobe <= 1'b1;
                            pre_cnt     <= PRE_RELOAD;
                            ms_left     <= dwell - 16'd1;
                        end else begin
                            wave_enable  <= 1'b0;
                            sweep_active <= 1'b0;
                            sweep_done   <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (rise) begin
                        start_t    <= uart_data_bus;
                        sweep_done <= 1'b0;
                        pre_cnt    <= PRE_RELOAD;
                        ms_left    <= CFG_TO_M1;
                        state      <= S_GET_STOP;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer. Three instances with CLKS_PER_MS=10 and a
// 5 ms configuration timeout:
//   dut0: STEP=1, LOOP=0
//   dut1: STEP=3, LOOP=0
//   dut2: STEP=1, LOOP=1
// The expected list of periods is generated from the sweep rules with
// integer arithmetic. Every cycle of a sweep is then compared against that
// list.
module tb_sweep_sequencer;

    localparam int CPM = 10;

    logic        clk_12mhz_int = 1'b0;
    logic        M_RESET_B;
    logic [15:0] data  [3];
    logic        valid [3];
    logic [15:0] wp    [3];
    logic        en    [3];
    logic        stb   [3];
    logic        act   [3];
    logic        dn    [3];

    int checks = 0;
    int errors = 0;
    int last_p [3];
    int exp_q [$];
    int strobe_seen;

    always #5 clk_12mhz_int = ~clk_12mhz_int;

    sweep_sequencer #(.CLKS_PER_MS(CPM), .STEP(16'd1), .LOOP(1'b0), .CFG_TIMEOUT_MS(5)) dut0 (
        .clk_12mhz_int(clk_12mhz_int), .M_RESET_B(M_RESET_B),
        .uart_data_bus(data[0]), .uart_data_valid(valid[0]),
        .wave_period(wp[0]), .wave_enable(en[0]), .step_strobe(stb[0]),
        .sweep_active(act[0]), .sweep_done(dn[0]));

    sweep_sequencer #(.CLKS_PER_MS(CPM), .STEP(16'd3), .LOOP(1'b0), .CFG_TIMEOUT_MS(5)) dut1 (
        .clk_12mhz_int(clk_12mhz_int), .M_RESET_B(M_RESET_B),
        .uart_data_bus(data[1]), .uart_data_valid(valid[1]),
        .wave_period(wp[1]), .wave_enable(en[1]), .step_strobe(stb[1]),
        .sweep_active(act[1]), .sweep_done(dn[1]));

    sweep_sequencer #(.CLKS_PER_MS(CPM), .STEP(16'd1), .LOOP(1'b1), .CFG_TIMEOUT_MS(5)) dut2 (
        .clk_12mhz_int(clk_12mhz_int), .M_RESET_B(M_RESET_B),
        .uart_data_bus(data[2]), .uart_data_valid(valid[2]),
        .wave_period(wp[2]), .wave_enable(en[2]), .step_strobe(stb[2]),
        .sweep_active(act[2]), .sweep_done(dn[2]));

    function automatic logic [19:0] obs(int k);
        return {dn[k], act[k], en[k], stb[k], wp[k]};
    endfunction

    // Expected vector layout: {done, active, enable, strobe, period}
    function automatic logic [19:0] vec(bit d, bit a, bit e, bit s, int p);
        return {d, a, e, s, 16'(p)};
    endfunction

    task automatic chk(string tag, logic [19:0] o, logic [19:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic send(int k, int d, int hold);
        @(negedge clk_12mhz_int);
        data[k]  = 16'(d);
        valid[k] = 1'b1;
        repeat (hold) @(negedge clk_12mhz_int);
        valid[k] = 1'b0;
    endtask

    // Sends the three configuration words, then checks every cycle of the
    // sweep. abort_at >= 0 sends an abort frame right after that cycle's
    // sample. Looping runs must give an abort point.
    task automatic run_sweep(int k, int st, int sp, int dw, int step, bit loop,
                             int ncyc, int abort_at, int hold_first, string tag);
        int h, n, total, cur;
        logic [19:0] e;
        send(k, st, hold_first);
        chk({tag, "_cfg1"}, obs(k), vec(0, 0, 0, 0, last_p[k]));
        send(k, sp, 1);
        chk({tag, "_cfg2"}, obs(k), vec(0, 0, 0, 0, last_p[k]));
        send(k, dw, 1);
        h = ((dw == 0) ? 1 : dw) * CPM;
        exp_q.delete();
        cur = st;
        exp_q.push_back(cur);
        while (cur != sp) begin
            if (sp > cur) cur = (sp - cur < step) ? sp : cur + step;
            else          cur = (cur - sp < step) ? sp : cur - step;
            exp_q.push_back(cur);
        end
        n = exp_q.size();
        total = loop ? ncyc : n * h + 3;
        strobe_seen = 0;
        for (int i = 0; i < total; i++) begin
            if (loop || i < n * h) e = vec(0, 1, 1, (i % h) == 0, exp_q[(i / h) % n]);
            else                   e = vec(1, 0, 0, 0, exp_q[n - 1]);
            chk($sformatf("%s_c%0d", tag, i), obs(k), e);
            if (stb[k]) strobe_seen++;
            if (i == abort_at) begin
                data[k]  = 16'h0055;
                valid[k] = 1'b1;
                @(negedge clk_12mhz_int);
                valid[k] = 1'b0;
                chk({tag, "_abort"}, obs(k), vec(0, 0, 0, 0, int'(e[15:0])));
                last_p[k] = int'(e[15:0]);
                return;
            end
            @(negedge clk_12mhz_int);
        end
        last_p[k] = exp_q[n - 1];
    endtask

    initial begin
        int st, sp, dw;
        M_RESET_B = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data[k] = 16'd0; valid[k] = 1'b0; last_p[k] = 0;
        end
        repeat (3) @(negedge clk_12mhz_int);
        for (int k = 0; k < 3; k++) chk($sformatf("reset_%0d", k), obs(k), 20'd0);
        M_RESET_B = 1'b1;

        // Basic up-sweep: 0x10..0x13 with 2 ms dwell, four strobes.
        run_sweep(0, 'h10, 'h13, 2, 1, 0, 0, -1, 1, "up");
        chk("up_strobes", 20'(strobe_seen), 20'd4);

        // Down-sweeps with STEP=3, one landing exactly on stop and one clamped.
        run_sweep(1, 'h20, 'h1A, 1, 3, 0, 0, -1, 1, "dn_exact");
        run_sweep(1, 'h20, 'h1B, 1, 3, 0, 0, -1, 1, "dn_clamp");
        run_sweep(1, 'hFFFA, 'hFFFF, 1, 3, 0, 0, -1, 1, "top_clamp");
        run_sweep(1, 'h0005, 'h0000, 1, 3, 0, 0, -1, 1, "bot_clamp");

        // A dwell of 0 is held as 1 ms.
        run_sweep(0, 'h05, 'h06, 0, 1, 0, 0, -1, 1, "dwell0");

        // Randomized sweeps.
        for (int r = 0; r < 4; r++) begin
            st = $urandom_range(0, 40); sp = $urandom_range(0, 40); dw = $urandom_range(0, 3);
            run_sweep(0, st, sp, dw, 1, 0, 0, -1, 1, $sformatf("rnd0_%0d", r));
            st = $urandom_range(0, 60); sp = $urandom_range(0, 60); dw = $urandom_range(0, 2);
            run_sweep(1, st, sp, dw, 3, 0, 0, -1, 1, $sformatf("rnd1_%0d", r));
        end
        st = $urandom_range(16'hFFC0, 16'hFFFF);
        run_sweep(1, st, 'hFFFF, 0, 3, 0, 0, -1, 1, "rnd_top");

        // Abort in the middle of the 0x11 dwell. The abort word must not be used as start.
        run_sweep(0, 'h10, 'h13, 2, 1, 0, 0, 25, 1, "abort_mid");
        run_sweep(0, 'h30, 'h31, 1, 1, 0, 0, -1, 1, "after_abort");
        // Abort coinciding with the dwell expiry: abort wins, no strobe.
        run_sweep(0, 'h10, 'h13, 2, 1, 0, 0, 19, 1, "abort_exp");
        run_sweep(0, 'h30, 'h32, 1, 1, 0, 0, -1, 1, "after_abort2");

        // Configuration timeouts from GET_STOP and from GET_DWELL.
        send(0, 'h77, 1);
        repeat (60) @(negedge clk_12mhz_int);
        chk("to_stop_idle", obs(0), vec(1'b0, 1'b0, 1'b0, 1'b0, last_p[0]));
        run_sweep(0, 'h40, 'h41, 1, 1, 0, 0, -1, 1, "after_to1");
        send(0, 'h77, 1);
        send(0, 'h78, 1);
        repeat (60) @(negedge clk_12mhz_int);
        run_sweep(0, 'h40, 'h42, 1, 1, 0, 0, -1, 1, "after_to2");

        // A valid level held high for 30 cycles counts as a single word.
        run_sweep(0, 'h21, 'h23, 1, 1, 0, 0, -1, 30, "long_valid");

        // Looping sweeps, including a 0xFFFF bypass value.
        run_sweep(2, 'hFFFF, 'hFFFF, 0, 1, 1, 50, 49, 1, "loop_ffff");
        run_sweep(2, 3, 5, 1, 1, 1, 75, 74, 1, "loop_3_5");
        run_sweep(2, 3, 5, 1, 1, 1, 100, 29, 1, "loop_abort_exp");

        // Asynchronous reset while in RUN, with a valid level already high at release.
        send(0, 'h10, 1);
        send(0, 'h20, 1);
        send(0, 'h01, 1);
        repeat (15) @(negedge clk_12mhz_int);
        #2 M_RESET_B = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("async_rst_%0d", k), obs(k), 20'd0);
        valid[0] = 1'b1;
        data[0]  = 16'h0099;
        @(negedge clk_12mhz_int);
        M_RESET_B = 1'b1;
        for (int k = 0; k < 3; k++) last_p[k] = 0;
        repeat (5) @(negedge clk_12mhz_int);
        chk("held_after_rst", obs(0), 20'd0);
        valid[0] = 1'b0;
        run_sweep(0, 'h50, 'h52, 1, 1, 0, 0, -1, 1, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
- Sits between the 12 MHz UART receive path (16-bit word + valid) and the 936 MHz square-wave generator's control inputs.
- Takes a 3-word sweep configuration from UART: start period, stop period, dwell in ms.
- Steps the division factor from start toward stop, holding each value for the dwell time, and drives wave_period/wave_enable.
- Replaces the single-tone IDLE/CONTINUOUS_WAVE controller for frequency-sweep builds.

Parameters:
- CLKS_PER_MS, 12000, clk cycles per 1 ms dwell tick.
- STEP, 1, period increment/decrement per dwell (16-bit, nonzero).
- LOOP, 0, 1 = restart at start value after reaching stop; 0 = stop once.
- CFG_TIMEOUT_MS, 1000, max ms between configuration words before the configuration is abandoned.

Ports:
- clk_12mhz_int  in  1  system clock, 12 MHz.
- M_RESET_B  in  1  asynchronous, active-low reset.
- uart_data_bus  in  16  received word; valid while uart_data_valid is high.
- uart_data_valid  in  1  level; high for ≥1 cycle per received frame.
- wave_period  out  16  division factor T to the generator.
- wave_enable  out  1  generator/PLL enable.
- step_strobe  out  1  1-cycle pulse whenever a new wave_period is applied in RUN.
- sweep_active  out  1  high in RUN.
- sweep_done  out  1  high in DONE.

Behaviour:
- Reset (async, M_RESET_B low): state=IDLE, wave_period=0, wave_enable=0, step_strobe=0, sweep_active=0, sweep_done=0, all counters/registers 0, valid_q=0.
- Frame detection:
  - valid_q registers uart_data_valid; rise = uart_data_valid & ~valid_q.
  - Only rise events are consumed. A level held high for many cycles counts as one frame.
- ms_tick: prescaler counts 0..CLKS_PER_MS-1 and pulses on the wrap. The prescaler and ms counter clear on every state entry.
- IDLE: on rise, start_T <= data; go to GET_STOP.
- GET_STOP:
  - On rise: stop_T <= data; go to GET_DWELL.
  - If CFG_TIMEOUT_MS ms elapse with no rise: go to IDLE.
- GET_DWELL:
  - On rise: dwell <= (data==0 ? 1 : data); go to RUN.
  - In the same edge: wave_period <= start_T, wave_enable <= 1, step_strobe <= 1.
  - Timeout behaves as in GET_STOP.
- RUN:
  - sweep_active=1. Each value is held exactly dwell*CLKS_PER_MS cycles, counted from the cycle wave_period updates.
  - At dwell expiry with cur != stop_T: move cur toward stop_T by STEP (up if stop_T > start_T, down otherwise). If |stop_T - cur| < STEP, clamp to stop_T. Assert step_strobe; stay in RUN.
  - At dwell expiry with cur == stop_T:
    - LOOP=1: reload start_T, assert step_strobe.
    - LOOP=0: go to DONE; wave_enable <= 0.
  - start_T == stop_T: a single-value sweep; that value is held for one dwell.
  - Arithmetic is unsigned 16-bit, computed in 17 bits; it never wraps past 0 or 0xFFFF. Period 0xFFFF passes through unchanged (downstream treats it as bypass).
- Abort: a rise in RUN goes to IDLE. wave_enable=0 and sweep_active=0 the next cycle; wave_period keeps its last value. The aborting frame is discarded, not taken as start_T.
- Simultaneous events: a rise coinciding with dwell expiry is an abort; the abort wins and no step_strobe is issued.
- DONE:
  - sweep_done=1, wave_enable=0.
  - A rise captures start_T and goes to GET_STOP, clearing sweep_done the next cycle.
- Latency: outputs update exactly 1 clk after the cycle in which rise is high.
- Reset mid-sweep: immediate return to reset values; no partial step.

Test Plan:
- Sim with CLKS_PER_MS=10, STEP=1, LOOP=0.
- Frames 0x0010, 0x0013, 0x0002 → wave_period 0x10, 0x11, 0x12, 0x13, each held 20 cycles. 4 step_strobe pulses. wave_enable falls 80 cycles after the first update, then sweep_done=1.
- Down-sweep with STEP=3: frames 0x0020, 0x001A, 0x0001 → periods 0x20, 0x1D, 0x1A (exact stop). Repeat with stop 0x001B → 0x20, 0x1D, 0x1B (clamped).
- Abort: a 4th frame mid-dwell of period 0x11 → wave_enable=0 one cycle later, state IDLE, wave_period stays 0x11, the frame is not used as start.
- Timeout: CFG_TIMEOUT_MS=5, send one frame then nothing for 50 cycles → back in IDLE. The next frame 0x0040 is taken as start_T.
- Edge cases:
  - dwell=0 → treated as 1 ms (10 cycles).
  - LOOP=1, start=stop=0xFFFF → wave_period stays 0xFFFF with a strobe every 10 cycles.
  - uart_data_valid held high 30 cycles → exactly one word consumed.
- Assert M_RESET_B low mid-RUN → all outputs 0 asynchronously. After release, the sequencer is in IDLE and ignores a valid level already high until its next rising edge.
